memory_bus_controller: RTL

- Parametrised successor to the flat ROM/RAM/switch address decoder.
- Decodes a 32-bit byte address into the ROM window, the RAM window and a switch I/O register block.
- Sequences external synchronous ROM/RAM through a req/ready, rvalid/rready handshake with fixed latency.
- Adds switch synchronisation, sticky edge capture and error reporting with a saturating error counter.

---
 rtl/memory_bus_controller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/memory_bus_controller.sv
// Memory bus controller: decodes a byte address into ROM, RAM and switch I/O, and sequences
// fixed-latency synchronous memories behind a req/ready, rvalid/rready handshake.
module memory_bus_controller #(
   parameter int unsigned ROM_DEPTH = 256,
   parameter int unsigned RAM_DEPTH = 256,
   parameter int unsigned MEM_W     = 8,
   parameter int unsigned NUM_SW    = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req,
   input  logic                         we,
   input  logic [31:0]                  address,
   input  logic [31:0]                  wdata,
   output logic                         ready,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [31:0]                  rdata,
   output logic                         err,
   output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
   input  logic [MEM_W-1:0]             rom_data,
   output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
   output logic                         ram_we,
   output logic [MEM_W-1:0]             ram_wdata,
   input  logic [MEM_W-1:0]             ram_rdata,
   input  logic [NUM_SW-1:0]            sw
);
   localparam int unsigned ROM_AW  = $clog2(ROM_DEPTH);
   localparam int unsigned RAM_AW  = $clog2(RAM_DEPTH);
   localparam int unsigned IO_BASE = ROM_DEPTH + RAM_DEPTH;

   typedef enum logic [1:0] {StIdle, StAccess, StLatch, StResp} state_e;
   typedef enum logic [2:0] {
      RgRom, RgRam, RgSwLevel, RgSwBit, RgEdge, RgErrCnt, RgErr
   } region_e;

   state_e            state_q, state_d;
   region_e           region_d, region_q;
   logic [4:0]        sw_idx_d, sw_idx_q;
   logic              we_q;
   logic [NUM_SW-1:0] clr_q;
   logic [ROM_AW-1:0] rom_addr_q;
   logic [RAM_AW-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [MEM_W-1:0]  ram_wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [31:0]       io_off, ram_off;
   logic              accept, latch;
   logic [NUM_SW-1:0] sw_meta_q, sw_sync_q, sw_prev_q;
   logic [NUM_SW-1:0] edge_q, edge_d, edge_clr;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [31:0]       lat_rdata;
   logic              lat_err, cnt_clr, lvl_bit;
   logic              unused_bits;

   assign unused_bits = ^{wdata, ram_off};

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (req) state_d = StAccess;
         StAccess: state_d = StLatch;
         StLatch:  state_d = StResp;
         StResp:   if (rready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready  = (state_q == StIdle);
      rvalid = (state_q == StResp);
      accept = ready && req;
      latch  = (state_q == StLatch);
   end

   // Address decode of the incoming request; errors are resolved here so ram_we never fires
   always_comb begin
      io_off   = address - IO_BASE;
      ram_off  = address - ROM_DEPTH;
      region_d = RgErr;
      sw_idx_d = '0;
      if (address < ROM_DEPTH)                 region_d = we ? RgErr : RgRom;
      else if (address < IO_BASE)              region_d = RgRam;
      else if (io_off[1:0] != 2'b00)           region_d = RgErr;
      else if (io_off == 32'h0)                region_d = we ? RgErr : RgSwLevel;
      else if (io_off <= 32'(4 * NUM_SW)) begin
         region_d = we ? RgErr : RgSwBit;
         sw_idx_d = io_off[6:2] - 5'd1;
      end
      else if (io_off == 32'h80)               region_d = RgEdge;
      else if (io_off == 32'h84)               region_d = RgErrCnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_q    <= RgErr;
         we_q        <= 1'b0;
         sw_idx_q    <= '0;
         clr_q       <= '0;
         rom_addr_q  <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         ram_we_q <= 1'b0;
         if (accept) begin
            region_q    <= region_d;
            we_q        <= we;
            sw_idx_q    <= sw_idx_d;
            clr_q       <= wdata[NUM_SW-1:0];
            ram_wdata_q <= wdata[MEM_W-1:0];
            if (region_d == RgRom) rom_addr_q <= address[ROM_AW-1:0];
            if (region_d == RgRam) begin
               ram_addr_q <= ram_off[RAM_AW-1:0];
               ram_we_q   <= we;
            end
         end
      end
   end

   always_comb begin
      lvl_bit = 1'b0;
      for (int unsigned k = 0; k < NUM_SW; k++) begin
         if (sw_idx_q == 5'(k)) lvl_bit = sw_sync_q[k];
      end
   end

   // Response data and register side effects, evaluated in the LATCH cycle
   always_comb begin
      lat_rdata = '0;
      lat_err   = 1'b0;
      edge_clr  = '0;
      cnt_clr   = 1'b0;
      unique case (region_q)
         RgRom:     lat_rdata = 32'(rom_data);
         RgRam:     if (!we_q) lat_rdata = 32'(ram_rdata);
         RgSwLevel: lat_rdata = 32'(sw_sync_q);
         RgSwBit:   lat_rdata = {31'b0, lvl_bit};
         RgEdge:    if (we_q) edge_clr = clr_q; else lat_rdata = 32'(edge_q);
         RgErrCnt:  if (we_q) cnt_clr = 1'b1; else lat_rdata = 32'(err_cnt_q);
         default:   lat_err = 1'b1;
      endcase
   end

   // A new rising edge in the same cycle as a clear keeps the bit set
   always_comb begin
      edge_d    = (edge_q & ~(latch ? edge_clr : '0)) | (sw_sync_q & ~sw_prev_q);
      err_cnt_d = err_cnt_q;
      if (latch) begin
         if (cnt_clr)                             err_cnt_d = '0;
         else if (lat_err && err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         sw_prev_q <= '0;
         edge_q    <= '0;
         err_cnt_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
         sw_prev_q <= sw_sync_q;
         edge_q    <= edge_d;
         err_cnt_q <= err_cnt_d;
         if (latch) begin
            rdata_q <= lat_rdata;
            err_q   <= lat_err;
         end
      end
   end

   assign rdata     = rdata_q;
   assign err       = err_q;
   assign rom_addr  = rom_addr_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;

endmodule
